// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes, FSM state types and address helper
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rd_state_t;

  // Number of byte-offset bits below the word index.
  function automatic int calc_ofs(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_lite_wr_fsm.sv
// rtl/axi_lite_wr_fsm.sv - write channel controller: independent AW/W capture and B response
module axi_lite_wr_fsm
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [ADDR_W-1:0]                     awaddr,
  input  logic                                  awvalid,
  output logic                                  awready,
  input  logic [DATA_W-1:0]                     wdata,
  input  logic [DATA_W/8-1:0]                   wstrb,
  input  logic                                  wvalid,
  output logic                                  wready,
  output logic                                  bvalid,
  output resp_t                                 bresp,
  input  logic                                  bready,
  output logic                                  we,
  output logic [ADDR_W-calc_ofs(DATA_W)-1:0]    widx,
  output logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W/8-1:0]                   wr_strb,
  output logic                                  wr_in_range
);

  localparam int OFS    = calc_ofs(DATA_W);
  localparam int IDX_W  = ADDR_W - OFS;
  localparam int STRB_W = DATA_W / 8;

  wr_state_t           state, nstate;
  logic [IDX_W-1:0]    aw_idx_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                aw_hs, w_hs;
  logic                awready_d, wready_d, bvalid_d;
  resp_t               bresp_d;
  logic                unused_ofs;

  assign unused_ofs = ^awaddr[OFS-1:0];

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Commit happens on the edge where the last of address/data arrives.
  assign we          = (aw_hs || state == W_HAVE_AW) && (w_hs || state == W_HAVE_W);
  assign widx        = aw_hs ? awaddr[ADDR_W-1:OFS] : aw_idx_q;
  assign wr_data     = w_hs ? wdata : w_data_q;
  assign wr_strb     = w_hs ? wstrb : w_strb_q;
  assign wr_in_range = {1'b0, widx} < (IDX_W+1)'(NUM_REGS);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= W_IDLE;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
    end else begin
      state   <= nstate;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
      if (aw_hs) aw_idx_q <= awaddr[ADDR_W-1:OFS];
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      W_IDLE: begin
        if (aw_hs && w_hs) nstate = W_RESP;
        else if (aw_hs)    nstate = W_HAVE_AW;
        else if (w_hs)     nstate = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)   nstate = W_RESP;
      W_HAVE_W:  if (aw_hs)  nstate = W_RESP;
      W_RESP:    if (bready) nstate = W_IDLE;
      default:               nstate = W_IDLE;
    endcase
  end

  // Channel readys and the response are registered from the next state.
  always_comb begin
    awready_d = (nstate == W_IDLE) || (nstate == W_HAVE_W);
    wready_d  = (nstate == W_IDLE) || (nstate == W_HAVE_AW);
    bvalid_d  = (nstate == W_RESP);
    bresp_d   = bresp;
    if (we) bresp_d = wr_in_range ? OKAY : SLVERR;
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI-Lite register file: storage, read channel and write controller
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BVALID,
  output logic [1:0]            BRESP,
  input  logic                  BREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int OFS    = calc_ofs(DATA_W);
  localparam int IDX_W  = ADDR_W - OFS;
  localparam int STRB_W = DATA_W / 8;

  logic                we, wr_in_range;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  axi_lite_wr_fsm #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_fsm (
    .aclk        (ACLK),
    .aresetn     (ARESETn),
    .awaddr      (AWADDR),
    .awvalid     (AWVALID),
    .awready     (AWREADY),
    .wdata       (WDATA),
    .wstrb       (WSTRB),
    .wvalid      (WVALID),
    .wready      (WREADY),
    .bvalid      (BVALID),
    .bresp       (BRESP),
    .bready      (BREADY),
    .we          (we),
    .widx        (wr_idx),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_in_range (wr_in_range)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wr_in_range) begin
      for (int i = 0; i < NUM_REGS; i++)
        for (int k = 0; k < STRB_W; k++)
          if (wr_idx == IDX_W'(i) && wr_strb[k]) regs[i][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  rd_state_t          rstate, rnext;
  logic               ar_hs, rd_in_range;
  logic [IDX_W-1:0]   ridx;
  logic [DATA_W-1:0]  rd_word, rdata_d;
  resp_t              rresp_d;
  logic               arready_d, rvalid_d;
  logic               unused_ar_ofs;

  assign unused_ar_ofs = ^ARADDR[OFS-1:0];
  assign ar_hs         = ARVALID && ARREADY;
  assign ridx          = ARADDR[ADDR_W-1:OFS];
  assign rd_in_range   = {1'b0, ridx} < (IDX_W+1)'(NUM_REGS);

  // Pre-edge storage contents, so a colliding write is not visible; misses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ridx == IDX_W'(i)) rd_word = regs[i];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= OKAY;
    end else begin
      rstate  <= rnext;
      ARREADY <= arready_d;
      RVALID  <= rvalid_d;
      RDATA   <= rdata_d;
      RRESP   <= rresp_d;
    end
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs)  rnext = R_VALID;
      R_VALID: if (RREADY) rnext = R_IDLE;
      default:             rnext = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (rnext == R_IDLE);
    rvalid_d  = (rnext == R_VALID);
    rdata_d   = RDATA;
    rresp_d   = resp_t'(RRESP);
    if (ar_hs) begin
      rdata_d = rd_word;
      rresp_d = rd_in_range ? OKAY : SLVERR;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - directed self-checking bench for axi_lite_regfile
module tb_axi_lite_regfile;

  logic        ACLK;
  logic        ARESETn;
  logic [7:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;
  logic [7:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_regfile dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BRESP   (BRESP),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] resp, output int waits);
    bit seen = 0;
    waits = 0;
    while (!seen && waits < 20) begin
      @(negedge ACLK);
      if (BVALID) seen = 1;
      else waits++;
    end
    check_eq("b_ack", {63'd0, seen}, 64'd1);
    resp = BRESP;
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output int b_waits);
    bit aw_done = 0;
    bit w_done = 0;
    int c = 0;
    @(posedge ACLK); #1;
    AWADDR = addr;
    WDATA  = data;
    WSTRB  = strb;
    while (!(aw_done && w_done) && c < 40) begin
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      @(negedge ACLK);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      @(posedge ACLK); #1;
      c++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check_eq("wr_hs", {63'd0, aw_done && w_done}, 64'd1);
    wait_b(resp, b_waits);
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit fired = 0;
    bit seen = 0;
    int c = 0;
    @(posedge ACLK); #1;
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!fired && c < 20) begin
      @(negedge ACLK);
      fired = ARREADY;
      @(posedge ACLK); #1;
      c++;
    end
    ARVALID = 1'b0;
    check_eq("ar_hs", {63'd0, fired}, 64'd1);
    c = 0;
    while (!seen && c < 20) begin
      @(negedge ACLK);
      if (RVALID) seen = 1;
      else c++;
    end
    check_eq("r_ack", {63'd0, seen}, 64'd1);
    data   = RDATA;
    resp   = RRESP;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  task automatic wr_expect(input string tag, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input logic [1:0] exp_resp);
    logic [1:0] resp;
    int         waits;
    do_write(addr, data, strb, aw_dly, w_dly, resp, waits);
    check_eq({tag, "_bresp"}, {62'd0, resp}, {62'd0, exp_resp});
    check_eq({tag, "_blat"}, waits, 0);
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
    logic [31:0] data;
    logic [1:0]  resp;
    do_read(addr, data, resp);
    check_eq({tag, "_rdata"}, {32'd0, data}, {32'd0, exp_data});
    check_eq({tag, "_rresp"}, {62'd0, resp}, {62'd0, exp_resp});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_awready"}, {63'd0, AWREADY}, 64'd0);
    check_eq({tag, "_wready"},  {63'd0, WREADY},  64'd0);
    check_eq({tag, "_arready"}, {63'd0, ARREADY}, 64'd0);
    check_eq({tag, "_bvalid"},  {63'd0, BVALID},  64'd0);
    check_eq({tag, "_rvalid"},  {63'd0, RVALID},  64'd0);
    check_eq({tag, "_bresp"},   {62'd0, BRESP},   64'd0);
    check_eq({tag, "_rresp"},   {62'd0, RRESP},   64'd0);
    check_eq({tag, "_rdata"},   {32'd0, RDATA},   64'd0);
  endtask

  task automatic check_readys(input string tag, input logic exp);
    check_eq({tag, "_awready"}, {63'd0, AWREADY}, {63'd0, exp});
    check_eq({tag, "_wready"},  {63'd0, WREADY},  {63'd0, exp});
    check_eq({tag, "_arready"}, {63'd0, ARREADY}, {63'd0, exp});
  endtask

  initial begin
    ARESETn = 1'b0;
    AWADDR  = '0; AWVALID = 1'b0;
    WDATA   = '0; WSTRB   = '0; WVALID = 1'b0;
    BREADY  = 1'b0;
    ARADDR  = '0; ARVALID = 1'b0;
    RREADY  = 1'b0;

    repeat (2) @(negedge ACLK);
    check_all_zero("rst");
    #2 ARESETn = 1'b1;
    #1 check_eq("rst_rel_awready", {63'd0, AWREADY}, 64'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    check_readys("post_rst", 1'b1);

    // Same-cycle AW/W, then read back.
    wr_expect("w04", 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    rd_expect("r04", 8'h04, 32'hDEADBEEF, 2'b00);

    // W three cycles ahead of AW, then a low-halfword strobe merge.
    wr_expect("w08_wfirst", 8'h08, 32'h11223344, 4'hF, 3, 0, 2'b00);
    wr_expect("w08_strb3",  8'h08, 32'hAAAA5555, 4'h3, 0, 0, 2'b00);
    rd_expect("r08", 8'h08, 32'h11225555, 2'b00);
    wr_expect("w08_strb0",  8'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00);
    rd_expect("r08_strb0", 8'h08, 32'h11225555, 2'b00);

    // AW ahead of W at the last implemented index; low address bits ignored.
    wr_expect("w3c_awfirst", 8'h3C, 32'h0BADF00D, 4'hF, 0, 2, 2'b00);
    rd_expect("r3f", 8'h3F, 32'h0BADF00D, 2'b00);

    // Out of range: index 16 must not alias onto index 0.
    wr_expect("w40", 8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10);
    rd_expect("r40", 8'h40, 32'h00000000, 2'b10);
    rd_expect("rfc", 8'hFC, 32'h00000000, 2'b10);
    rd_expect("r00", 8'h00, 32'h00000000, 2'b00);
    rd_expect("r3c", 8'h3C, 32'h0BADF00D, 2'b00);

    // Back-pressure on both B and R for five cycles.
    @(posedge ACLK); #1;
    AWADDR = 8'h10; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 8'h04; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check_eq("stall_bvalid", {63'd0, BVALID}, 64'd1);
      check_eq("stall_bresp",  {62'd0, BRESP},  64'd0);
      check_eq("stall_rvalid", {63'd0, RVALID}, 64'd1);
      check_eq("stall_rdata",  {32'd0, RDATA},  64'hDEADBEEF);
      check_eq("stall_rresp",  {62'd0, RRESP},  64'd0);
      check_readys("stall", 1'b0);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    check_eq("unstall_bvalid", {63'd0, BVALID}, 64'd0);
    check_eq("unstall_rvalid", {63'd0, RVALID}, 64'd0);
    check_readys("unstall", 1'b1);
    rd_expect("r10", 8'h10, 32'hCAFEF00D, 2'b00);

    // Read and write to the same index on the same edge sees the old value.
    @(posedge ACLK); #1;
    AWADDR = 8'h0C; WDATA = 32'h12345678; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 8'h0C; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    check_eq("coll_rvalid", {63'd0, RVALID}, 64'd1);
    check_eq("coll_rdata",  {32'd0, RDATA},  64'd0);
    check_eq("coll_bvalid", {63'd0, BVALID}, 64'd1);
    check_eq("coll_bresp",  {62'd0, BRESP},  64'd0);
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    rd_expect("r0c", 8'h0C, 32'h12345678, 2'b00);

    // Reset while an AW is held.
    @(posedge ACLK); #1;
    AWADDR = 8'h14; AWVALID = 1'b1;
    @(negedge ACLK);
    check_eq("held_aw_awready", {63'd0, AWREADY}, 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK);
    check_eq("held_aw_wready",   {63'd0, WREADY},  64'd1);
    check_eq("held_aw_awready2", {63'd0, AWREADY}, 64'd0);
    #1 ARESETn = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_readys("midrst_rel", 1'b1);
    rd_expect("r04_cleared", 8'h04, 32'h00000000, 2'b00);
    wr_expect("w18_after_rst", 8'h18, 32'h00000055, 4'hF, 3, 0, 2'b00);
    rd_expect("r14_after_rst", 8'h14, 32'h00000000, 2'b00);
    rd_expect("r18_after_rst", 8'h18, 32'h00000055, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 Parameter ADDR_W, 8, byte-address width of AWADDR/ARADDR.
REQ-002 Parameter DATA_W, 32, data width; legal values are 32 and 64.
REQ-003 Parameter NUM_REGS, 16, number of implemented registers; minimum 1, maximum 2**(ADDR_W-log2(DATA_W/8)).
REQ-004 Clock and reset SHALL be one clock and an asynchronous, active-low reset, named ACLK and ARESETn.
REQ-005 Ports:
- ACLK in 1: clock.
- ARESETn in 1: async active-low reset.
- AWADDR in ADDR_W: write address.
- AWVALID in 1: write address valid.
- AWREADY out 1: write address ready.
- WDATA in DATA_W: write data.
- WSTRB in DATA_W/8: byte strobes.
- WVALID in 1: write data valid.
- WREADY out 1: write data ready.
- BVALID out 1: write response valid.
- BRESP out 2: write response.
- BREADY in 1: write response ready.
- ARADDR in ADDR_W: read address.
- ARVALID in 1: read address valid.
- ARREADY out 1: read address ready.
- RDATA out DATA_W: read data.
- RRESP out 2: read response.
- RVALID out 1: read valid.
- RREADY in 1: read ready.

Function
REQ-006 Word index SHALL be addr[ADDR_W-1:OFS], with OFS=log2(DATA_W/8); low OFS bits are ignored.
REQ-007 Index >= NUM_REGS SHALL be out of range: response SLVERR (2'b10), and no register changes. In-range accesses SHALL return OKAY (2'b00).
REQ-008 The AW and W channels SHALL be accepted independently, in either order or in the same cycle. Each is captured into its own holding register.
REQ-009 Write FSM states:
- W_IDLE.
- W_HAVE_AW: AW held, waiting for W.
- W_HAVE_W: W held, waiting for AW.
- W_RESP: BVALID high.
REQ-010 AWREADY SHALL be high only in W_IDLE and W_HAVE_W. WREADY SHALL be high only in W_IDLE and W_HAVE_AW. Both SHALL be low in W_RESP.
REQ-011 On the edge where both the address and the data become available (held or handshaking that edge):
- update the register in the same edge;
- assert BVALID with BRESP;
- go to W_RESP.
REQ-012 Write update SHALL apply per byte: byte k is written only when WSTRB[k]=1. WSTRB=0 in range SHALL return OKAY with no change.
REQ-013 BVALID and BRESP SHALL hold stable until BREADY. On the B handshake edge the FSM SHALL return to W_IDLE with AWREADY=WREADY=1.
REQ-014 Read FSM states:
- R_IDLE: ARREADY=1.
- R_VALID: ARREADY=0, RVALID=1.
REQ-015 An AR handshake at edge N SHALL register RDATA/RRESP at edge N (RVALID visible after N).
REQ-016 Out-of-range reads SHALL return RDATA=0.
REQ-017 RDATA/RRESP SHALL stay stable while RVALID && !RREADY. On the R handshake the FSM SHALL return to R_IDLE.
REQ-018 Read and write channels SHALL operate concurrently. A read sampled on the same edge as a write to the same index SHALL return the pre-write value.
REQ-019 All outputs SHALL be driven from flops.

Reset
REQ-020 While ARESETn=0, every register SHALL be 0 and these outputs SHALL be 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA. Both FSMs SHALL be in their IDLE state.
REQ-021 AWREADY, WREADY and ARREADY SHALL rise on the first ACLK edge after ARESETn deasserts.
REQ-022 Reset asserted mid-transaction SHALL discard held AW/W and any pending B/R responses, without updating any register.

Structure
REQ-023 Package axi_lite_pkg SHALL hold:
- resp_t (OKAY=2'b00, SLVERR=2'b10);
- write FSM state typedef;
- read FSM state typedef;
- helper function computing OFS.
REQ-024 The write channel controller SHALL be a sub-module named axi_lite_wr_fsm, which outputs the write enable, index, data, strobes and in-range flag. Storage and read logic SHALL stay in the top.

Verification
REQ-025 All scenarios use the default parameters.
REQ-026 AW 0x04 and W 0xDEADBEEF with WSTRB 0xF in the same cycle, then AR 0x04 -> BRESP OKAY one edge later; RDATA 0xDEADBEEF, RRESP OKAY.
REQ-027 W 0x11223344 sent 3 cycles before AW 0x08, then WSTRB 0x3 write 0xAAAA5555 to 0x08 -> read returns 0x11225555.
REQ-028 AW 0x40 (index 16) -> BRESP SLVERR, no register changes. AR 0x40 -> RDATA 0, RRESP SLVERR.
REQ-029 Hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stable. AWREADY, WREADY and ARREADY stay 0 until the handshake.
REQ-030 AR 0x0C and write of 0x12345678 to 0x0C handshake on the same edge, register initially 0 -> RDATA 0; a subsequent read returns 0x12345678.
REQ-031 Assert ARESETn=0 after AW is accepted but before W -> all outputs 0 during reset, and all readys 1 one edge after release. A later read of that address returns 0.
